// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD constants, state encoding and helpers for the BCD counter family.
package bcd_down_counter_pkg;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_ONE  = 4'd1;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the decrement chain: decrements when a borrow arrives, wrapping 0 to 9.
module bcd_digit_dec
  import bcd_down_counter_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       borrow_in,
  output logic [3:0] digit_out,
  output logic       borrow_out
);

  always_comb begin
    borrow_out = borrow_in && (digit_in == BCD_ZERO);
    digit_out  = digit_in;
    if (borrow_in) begin
      digit_out = (digit_in == BCD_ZERO) ? BCD_NINE : digit_in - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// N-digit BCD countdown timer with prescaler, pause/resume, terminal-count pulse and
// optional auto-reload of the loaded preset.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter int PRESCALE    = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                start,
  input  logic                stop,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                running,
  output logic                done,
  output logic                load_err
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t          state, state_nxt;
  logic [W-1:0]    count, count_nxt, count_dec;
  logic [W-1:0]    preset, preset_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic            done_nxt, err_nxt;
  logic            load_ok;
  logic            tick;
  logic [DIGITS:0] borrow;

  // The borrow out of the top digit is set exactly when the whole count is zero.
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    bcd_digit_dec u_digit (
      .digit_in  (count[4*i +: 4]),
      .borrow_in (borrow[i]),
      .digit_out (count_dec[4*i +: 4]),
      .borrow_out(borrow[i+1])
    );
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_ok(load_value[4*i +: 4])) load_ok = 1'b0;
    end
  end

  assign tick = (presc == PRESC_LAST);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    preset_nxt = preset;
    presc_nxt  = presc;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_nxt  = load_value;
        preset_nxt = load_value;
        presc_nxt  = '0;
        state_nxt  = ST_IDLE;
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (!stop && start && !borrow[DIGITS]) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (stop) begin
            state_nxt = ST_PAUSE;
          end else if (tick) begin
            presc_nxt = '0;
            // Terminal count: either reload and keep going, or park at zero in DONE.
            if (count == W'(BCD_ONE)) begin
              done_nxt = 1'b1;
              if (AUTO_RELOAD != 0) begin
                count_nxt = preset;
              end else begin
                count_nxt = '0;
                state_nxt = ST_DONE;
              end
            end else begin
              count_nxt = count_dec;
            end
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (!stop && start) state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      preset   <= '0;
      presc    <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      preset   <= preset_nxt;
      presc    <= presc_nxt;
      running  <= (state_nxt == ST_RUN);
      done     <= done_nxt;
      load_err <= err_nxt;
    end
  end

  assign bcd_out = count;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench: three counter configurations share stimulus; an integer-level model
// predicts each cycle's outputs, and a negedge monitor pops and compares them.
module tb_bcd_down_counter;

  localparam int NDUT = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct {
    int count;
    int preset;
    int presc;
    int mode;
    bit run;
    bit done;
    bit err;
  } model_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] load_value = 12'h000;

  logic [11:0] bcd_o  [NDUT];
  logic        run_o  [NDUT];
  logic        done_o [NDUT];
  logic        err_o  [NDUT];

  model_t      m [NDUT];
  logic [44:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  bcd_down_counter #(.DIGITS(3), .PRESCALE(1), .AUTO_RELOAD(0)) u_dut0 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .start(start), .stop(stop),
    .bcd_out(bcd_o[0]), .running(run_o[0]), .done(done_o[0]), .load_err(err_o[0]));

  bcd_down_counter #(.DIGITS(3), .PRESCALE(4), .AUTO_RELOAD(0)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .start(start), .stop(stop),
    .bcd_out(bcd_o[1]), .running(run_o[1]), .done(done_o[1]), .load_err(err_o[1]));

  bcd_down_counter #(.DIGITS(3), .PRESCALE(1), .AUTO_RELOAD(1)) u_dut2 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value), .start(start), .stop(stop),
    .bcd_out(bcd_o[2]), .running(run_o[2]), .done(done_o[2]), .load_err(err_o[2]));

  initial forever #5 clk = ~clk;

  function automatic int cfg_prescale(int k);
    return (k == 1) ? 4 : 1;
  endfunction

  function automatic bit cfg_reload(int k);
    return (k == 2);
  endfunction

  function automatic bit valid_bcd(logic [11:0] v);
    return (v[3:0] < 4'd10) && (v[7:4] < 4'd10) && (v[11:8] < 4'd10);
  endfunction

  function automatic int bcd2int(logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.count = 0; r.preset = 0; r.presc = 0; r.mode = M_IDLE;
    r.run = 0; r.done = 0; r.err = 0;
    return r;
  endfunction

  // One clock of the timer described in plain integer terms.
  function automatic model_t model_step(model_t s, int ps, bit ar, bit ld, logic [11:0] lv,
                                        bit st, bit sp);
    model_t n = s;
    n.done = 0;
    n.err  = 0;
    if (ld) begin
      if (valid_bcd(lv)) begin
        n.count = bcd2int(lv);
        n.preset = n.count;
        n.presc = 0;
        n.mode = M_IDLE;
      end else begin
        n.err = 1;
      end
    end else if (s.mode == M_RUN && sp) begin
      n.mode = M_PAUSE;
    end else if (s.mode == M_IDLE && st && !sp && s.count > 0) begin
      n.mode = M_RUN;
    end else if (s.mode == M_PAUSE && st && !sp) begin
      n.mode = M_RUN;
    end else if (s.mode == M_RUN) begin
      n.presc = (s.presc + 1) % ps;
      if (n.presc == 0) begin
        if (s.count == 1) begin
          n.done = 1;
          if (ar) begin
            n.count = s.preset;
          end else begin
            n.count = 0;
            n.mode = M_DONE;
          end
        end else begin
          n.count = s.count - 1;
        end
      end
    end
    n.run = (n.mode == M_RUN);
    return n;
  endfunction

  function automatic logic [14:0] model_obs(model_t s);
    return {int2bcd(s.count), s.run, s.done, s.err};
  endfunction

  task automatic checkOutput(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got bcd=%h run=%b done=%b err=%b, expected bcd=%h run=%b done=%b err=%b",
               name, act[14:3], act[2], act[1], act[0], exp[14:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge and queue the predicted result.
  task automatic applyStimulus(input bit rst, input bit ld, input logic [11:0] lv,
                               input bit st, input bit sp);
    logic [44:0] e;
    @(negedge clk);
    #1;
    reset = rst; load = ld; load_value = lv; start = st; stop = sp;
    for (int k = 0; k < NDUT; k++) begin
      if (rst) m[k] = model_reset();
      else m[k] = model_step(m[k], cfg_prescale(k), cfg_reload(k), ld, lv, st, sp);
      e[k*15 +: 15] = model_obs(m[k]);
    end
    exp_q.push_back(e);
    if (rst) begin
      #1;
      for (int k = 0; k < NDUT; k++)
        checkOutput($sformatf("async_reset_dut%0d", k),
                    {bcd_o[k], run_o[k], done_o[k], err_o[k]}, 15'h0000);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic loadStart(input logic [11:0] lv);
    applyStimulus(1'b0, 1'b1, lv, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [44:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < NDUT; k++)
        checkOutput($sformatf("cycle_dut%0d", k),
                    {bcd_o[k], run_o[k], done_o[k], err_o[k]}, e[k*15 +: 15]);
    end
  end

  initial begin
    logic [11:0] lv;
    for (int k = 0; k < NDUT; k++) m[k] = model_reset();

    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    idle(1);

    loadStart(12'h003);
    idle(5);

    loadStart(12'h100);
    idle(3);
    loadStart(12'h010);
    idle(3);

    applyStimulus(1'b0, 1'b1, 12'h1A5, 1'b0, 1'b0);
    idle(2);

    loadStart(12'h005);
    idle(5);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    idle(10);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    idle(4);
    applyStimulus(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    idle(3);

    loadStart(12'h002);
    idle(8);

    loadStart(12'h057);
    idle(3);
    applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
    loadStart(12'h000);
    idle(3);

    // Random phase, biased toward small presets so terminal counts occur often.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 8)
        0: lv = 12'($urandom);
        1, 2, 3, 4: lv = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
        default: lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      applyStimulus(($urandom % 300) == 0, ($urandom % 20) == 0, lv,
                    ($urandom % 4) == 0, ($urandom % 12) == 0);
    end
    idle(2);
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
